// File: rtl/bcd_digit_scanner_if.sv
// ---------------------------------------------------------------------------
// bcd_digit_scanner_if
// Groups the load handshake and display bus of bcd_digit_scanner.
//   load            1-cycle strobe: capture digits_in into the shadow buffer
//   digits_in       packed BCD, nibble 0 = least-significant digit
//   update_pending  shadow holds data not yet shown
//   bcd             digit value currently on the shared bus
//   dig_en          one-hot, active-high digit enable
//   frame_done      one-cycle pulse after each completed frame
// master: the producer of digit data (drives load/digits_in).
// slave : the scanner itself.
// ---------------------------------------------------------------------------
interface bcd_digit_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    update_pending;
  logic [3:0]              bcd;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic                    frame_done;

  modport master (
    output load, digits_in,
    input  update_pending, bcd, dig_en, frame_done
  );

  modport slave (
    input  load, digits_in,
    output update_pending, bcd, dig_en, frame_done
  );
endinterface

// File: rtl/bcd_digit_scanner.sv
// ---------------------------------------------------------------------------
// bcd_digit_scanner
// Time-multiplexes NUM_DIGITS packed BCD digits onto one 4-bit bus with a
// one-hot active-high digit enable. Loads are double-buffered (shadow ->
// active at frame boundaries) so a frame never shows a mix of old and new
// digits; each slot starts with BLANK_CYCLES of dead time against ghosting.
//
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous reset, active-high
//   bus   slave modport of bcd_digit_scanner_if
//         (load, digits_in, update_pending, bcd, dig_en, frame_done)
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, digit i>0 stays dark for its whole slot if active nibbles
//   i..NUM_DIGITS-1 are all zero. Digit 0 is always lit.
// ---------------------------------------------------------------------------
module bcd_digit_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_digit_scanner_if.slave   bus
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // Registered state
  logic [PW-1:0]         presc_r;
  logic [IW-1:0]         idx_r;
  logic [DW-1:0]         shadow_r;
  logic [DW-1:0]         active_r;
  logic                  pending_r;
  logic                  frame_done_r;
  logic [3:0]            bcd_r;
  logic [NUM_DIGITS-1:0] dig_en_r;

  // Next-state values
  logic                  slot_end_s;
  logic                  frame_end_s;
  logic [PW-1:0]         presc_s;
  logic [IW-1:0]         idx_s;
  logic [DW-1:0]         shadow_s;
  logic [DW-1:0]         active_s;
  logic                  pending_s;
  logic [3:0]            bcd_s;
  logic [NUM_DIGITS-1:0] dig_en_s;

  function automatic logic [NUM_DIGITS-1:0] onehot(input logic [IW-1:0] i);
    logic [NUM_DIGITS-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Bit i is 0 when digit i and every more-significant digit are zero.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DW-1:0] act);
    logic [NUM_DIGITS-1:0] m;
    m = '1;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      m[i] = |(act >> (4 * i));
    end
    return m;
  endfunction
`endif

  // Next-state logic for scan timing, double buffer and decoded outputs
  always_comb begin
    slot_end_s  = (presc_r == PRESC_LAST);
    frame_end_s = slot_end_s && (idx_r == IDX_LAST);
    shadow_s    = shadow_r;
    active_s    = active_r;
    pending_s   = pending_r;

    if (slot_end_s) begin
      presc_s = '0;
      if (idx_r == IDX_LAST) begin
        idx_s = '0;
      end else begin
        idx_s = idx_r + IW'(1);
      end
    end else begin
      presc_s = presc_r + PW'(1);
      idx_s   = idx_r;
    end

    // A load on the boundary edge bypasses the shadow so it shows at once
    if (bus.load) begin
      shadow_s = bus.digits_in;
      if (frame_end_s) begin
        active_s  = bus.digits_in;
        pending_s = 1'b0;
      end else begin
        pending_s = 1'b1;
      end
    end else if (frame_end_s && pending_r) begin
      active_s  = shadow_r;
      pending_s = 1'b0;
    end else begin
      pending_s = pending_r;
    end

    // Outputs are precomputed from next state so they can be registered and
    // still change on the same edge as idx.
    bcd_s = active_s[int'(idx_s) * 4 +: 4];

    if (int'(presc_s) < BLANK_CYCLES) begin
      dig_en_s = '0;
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      dig_en_s = onehot(idx_s) & lz_mask(active_s);
`else
      dig_en_s = onehot(idx_s);
`endif
    end
  end

  // State and output registers; reset clears everything immediately.
  // With BLANK_CYCLES=0 the first cycle after reset stays dark, since
  // dig_en is only loaded on the first edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r      <= '0;
      idx_r        <= '0;
      shadow_r     <= '0;
      active_r     <= '0;
      pending_r    <= 1'b0;
      frame_done_r <= 1'b0;
      bcd_r        <= 4'd0;
      dig_en_r     <= '0;
    end else begin
      presc_r      <= presc_s;
      idx_r        <= idx_s;
      shadow_r     <= shadow_s;
      active_r     <= active_s;
      pending_r    <= pending_s;
      frame_done_r <= frame_end_s;
      bcd_r        <= bcd_s;
      dig_en_r     <= dig_en_s;
    end
  end

  assign bus.update_pending = pending_r;
  assign bus.bcd            = bcd_r;
  assign bus.dig_en         = dig_en_r;
  assign bus.frame_done     = frame_done_r;

endmodule
